// File: rtl/tlb_table_pkg.sv
// ============================================================================
// Package : mmu_defs
// Brief   : Shared MMU TLB constants: entry field layout, op codes, sizes.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package mmu_defs;

  localparam int TLB_ENTRIES = 16;
  localparam int ENTRY_W     = 80;
  localparam logic [3:0] RANDOM_RESET = 4'd15;

  // Stored entry field positions
  localparam int ASID_HI = 79;
  localparam int ASID_LO = 72;
  localparam int G_POS   = 71;
  localparam int VPN2_HI = 70;
  localparam int VPN2_LO = 52;
  localparam int PFN1_HI = 51;
  localparam int PFN1_LO = 28;
  localparam int D1_POS  = 27;
  localparam int V1_POS  = 26;
  localparam int PFN0_HI = 25;
  localparam int PFN0_LO = 2;
  localparam int D0_POS  = 1;
  localparam int V0_POS  = 0;

  typedef enum logic [1:0] {
    TLB_OP_READ = 2'b00,
    TLB_OP_WI   = 2'b01,
    TLB_OP_WR   = 2'b10,
    TLB_OP_P    = 2'b11
  } tlb_op_e;

  // Pack CP0 EntryHi/EntryLo0/EntryLo1 into the stored entry format.
  // G is stored only when both lo words mark the pair global.
  function automatic logic [ENTRY_W-1:0] pack_entry(input logic [31:0] hi,
                                                    input logic [31:0] lo0,
                                                    input logic [31:0] lo1);
    return {hi[7:0], lo0[0] & lo1[0], hi[31:13],
            lo1[29:6], lo1[2], lo1[1],
            lo0[29:6], lo0[2], lo0[1]};
  endfunction

endpackage

`default_nettype wire

// File: rtl/tlb_table_random.sv
// ============================================================================
// Module  : tlb_random
// Brief   : CP0 Random counter; decrements each cycle, wraps to 15 at Wired
//           or zero, and is forced to 15 on a Wired write.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tlb_random
  import mmu_defs::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] wired_i,
  input  logic       wired_we_i,
  output logic [3:0] random_o
);

  logic [3:0] random_q;
  logic [3:0] random_d;

  // Next value: Wired write wins, then wrap at Wired/zero, else decrement
  always_comb begin
    random_d = random_q - 4'd1;
    if (wired_we_i) begin
      random_d = RANDOM_RESET;
    end else if ((random_q == wired_i) || (random_q == 4'd0)) begin
      random_d = RANDOM_RESET;
    end
  end

  // Counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      random_q <= RANDOM_RESET;
    end else begin
      random_q <= random_d;
    end
  end

  assign random_o = random_q;

endmodule

`default_nettype wire

// File: rtl/tlb_table.sv
// ============================================================================
// Module  : tlb_table
// Brief   : TLB entry storage with TLBR/TLBWI/TLBWR/TLBP handshake FSM,
//           probe priority encoder and CP0 Random counter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tlb_table
  import mmu_defs::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        op_valid,
  output logic        op_ready,
  input  logic [1:0]  op,
  input  logic [3:0]  index,
  input  logic [3:0]  wired,
  input  logic        wired_we,
  input  logic [31:0] entry_hi,
  input  logic [31:0] entry_lo0,
  input  logic [31:0] entry_lo1,
  output logic        op_done,
  output logic [31:0] rd_entry_hi,
  output logic [31:0] rd_entry_lo0,
  output logic [31:0] rd_entry_lo1,
  output logic [3:0]  probe_index,
  output logic        probe_miss,
  output logic [3:0]  random,
  output logic [79:0] tlb_entry0,
  output logic [79:0] tlb_entry1,
  output logic [79:0] tlb_entry2,
  output logic [79:0] tlb_entry3,
  output logic [79:0] tlb_entry4,
  output logic [79:0] tlb_entry5,
  output logic [79:0] tlb_entry6,
  output logic [79:0] tlb_entry7,
  output logic [79:0] tlb_entry8,
  output logic [79:0] tlb_entry9,
  output logic [79:0] tlb_entry10,
  output logic [79:0] tlb_entry11,
  output logic [79:0] tlb_entry12,
  output logic [79:0] tlb_entry13,
  output logic [79:0] tlb_entry14,
  output logic [79:0] tlb_entry15
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PROBE = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  state_e                    state_q;
  state_e                    state_d;
  logic [ENTRY_W-1:0]        entry_q [TLB_ENTRIES];
  logic [TLB_ENTRIES-1:0]    match_q;
  logic [TLB_ENTRIES-1:0]    w_match;
  logic [31:0]               rd_hi_q;
  logic [31:0]               rd_lo0_q;
  logic [31:0]               rd_lo1_q;
  logic [3:0]                probe_index_q;
  logic                      probe_miss_q;

  tlb_op_e                   w_op;
  logic                      w_accept;
  logic                      w_we;
  logic [3:0]                w_widx;
  logic [ENTRY_W-1:0]        w_rd_entry;
  logic [3:0]                w_hit_idx;
  logic                      w_hit;
  logic [3:0]                w_random;
  logic                      w_unused_bits;

  assign w_op     = tlb_op_e'(op);
  assign op_ready = (state_q == ST_IDLE);
  assign op_done  = (state_q == ST_DONE);
  assign w_accept = op_valid & op_ready;

  // TLBWR targets the Random value visible in the accept cycle
  assign w_we   = w_accept & ((w_op == TLB_OP_WI) | (w_op == TLB_OP_WR));
  assign w_widx = (w_op == TLB_OP_WR) ? w_random : index;

  assign w_rd_entry = entry_q[index];

  // Field bits that the stored format has no room for
  assign w_unused_bits = ^{entry_hi[12:8],
                           entry_lo0[31:30], entry_lo0[5:3],
                           entry_lo1[31:30], entry_lo1[5:3]};

  tlb_random u_random (
    .clk        (clk),
    .rst        (rst),
    .wired_i    (wired),
    .wired_we_i (wired_we),
    .random_o   (w_random)
  );

  assign random = w_random;

  // Per-entry VPN2/ASID compare against EntryHi
  generate
    for (genvar gi = 0; gi < TLB_ENTRIES; gi++) begin : g_match
      assign w_match[gi] =
        (entry_q[gi][VPN2_HI:VPN2_LO] == entry_hi[31:13]) &&
        ((entry_q[gi][ASID_HI:ASID_LO] == entry_hi[7:0]) || entry_q[gi][G_POS]);
    end
  endgenerate

  // Lowest-numbered match wins
  always_comb begin
    w_hit_idx = 4'd0;
    w_hit     = |match_q;
    for (int i = TLB_ENTRIES - 1; i >= 0; i--) begin
      if (match_q[i]) begin
        w_hit_idx = 4'(i);
      end
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (w_accept) begin
          state_d = (w_op == TLB_OP_P) ? ST_PROBE : ST_DONE;
        end
      end
      ST_PROBE: state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Entry storage, written only from IDLE so probes see stable contents
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < TLB_ENTRIES; i++) begin
        entry_q[i] <= '0;
      end
    end else if (w_we) begin
      entry_q[w_widx] <= pack_entry(entry_hi, entry_lo0, entry_lo1);
    end
  end

  // TLBR result and TLBP match capture at the accept edge, probe encode in PROBE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_hi_q       <= '0;
      rd_lo0_q      <= '0;
      rd_lo1_q      <= '0;
      match_q       <= '0;
      probe_index_q <= '0;
      probe_miss_q  <= 1'b0;
    end else begin
      if (w_accept && (w_op == TLB_OP_READ)) begin
        rd_hi_q  <= {w_rd_entry[VPN2_HI:VPN2_LO], 5'b0, w_rd_entry[ASID_HI:ASID_LO]};
        rd_lo0_q <= {2'b0, w_rd_entry[PFN0_HI:PFN0_LO], 3'b0,
                     w_rd_entry[D0_POS], w_rd_entry[V0_POS], w_rd_entry[G_POS]};
        rd_lo1_q <= {2'b0, w_rd_entry[PFN1_HI:PFN1_LO], 3'b0,
                     w_rd_entry[D1_POS], w_rd_entry[V1_POS], w_rd_entry[G_POS]};
      end
      if (w_accept && (w_op == TLB_OP_P)) begin
        match_q <= w_match;
      end
      if (state_q == ST_PROBE) begin
        if (w_hit) begin
          probe_index_q <= w_hit_idx;
        end
        probe_miss_q <= ~w_hit;
      end
    end
  end

  assign rd_entry_hi  = rd_hi_q;
  assign rd_entry_lo0 = rd_lo0_q;
  assign rd_entry_lo1 = rd_lo1_q;
  assign probe_index  = probe_index_q;
  assign probe_miss   = probe_miss_q;

  assign tlb_entry0  = entry_q[0];
  assign tlb_entry1  = entry_q[1];
  assign tlb_entry2  = entry_q[2];
  assign tlb_entry3  = entry_q[3];
  assign tlb_entry4  = entry_q[4];
  assign tlb_entry5  = entry_q[5];
  assign tlb_entry6  = entry_q[6];
  assign tlb_entry7  = entry_q[7];
  assign tlb_entry8  = entry_q[8];
  assign tlb_entry9  = entry_q[9];
  assign tlb_entry10 = entry_q[10];
  assign tlb_entry11 = entry_q[11];
  assign tlb_entry12 = entry_q[12];
  assign tlb_entry13 = entry_q[13];
  assign tlb_entry14 = entry_q[14];
  assign tlb_entry15 = entry_q[15];

endmodule

`default_nettype wire

// File: tb/tb_tlb_table.sv
// ============================================================================
// Module  : tb_tlb_table
// Brief   : Directed self-checking bench for tlb_table with an expected-value
//           scoreboard popped at each op completion.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tlb_table;
  import mmu_defs::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        op_valid = 1'b0;
  logic        op_ready;
  logic [1:0]  op = 2'b00;
  logic [3:0]  index = 4'd0;
  logic [3:0]  wired = 4'd0;
  logic        wired_we = 1'b0;
  logic [31:0] entry_hi = '0;
  logic [31:0] entry_lo0 = '0;
  logic [31:0] entry_lo1 = '0;
  logic        op_done;
  logic [31:0] rd_entry_hi, rd_entry_lo0, rd_entry_lo1;
  logic [3:0]  probe_index;
  logic        probe_miss;
  logic [3:0]  random;
  logic [79:0] ent [16];

  int checks = 0;
  int failures = 0;
  logic [79:0] exp_q [$];
  logic [3:0]  r_exp;

  always #5 clk = ~clk;

  tlb_table dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op_ready(op_ready), .op(op),
    .index(index), .wired(wired), .wired_we(wired_we), .entry_hi(entry_hi),
    .entry_lo0(entry_lo0), .entry_lo1(entry_lo1), .op_done(op_done),
    .rd_entry_hi(rd_entry_hi), .rd_entry_lo0(rd_entry_lo0), .rd_entry_lo1(rd_entry_lo1),
    .probe_index(probe_index), .probe_miss(probe_miss), .random(random),
    .tlb_entry0(ent[0]), .tlb_entry1(ent[1]), .tlb_entry2(ent[2]), .tlb_entry3(ent[3]),
    .tlb_entry4(ent[4]), .tlb_entry5(ent[5]), .tlb_entry6(ent[6]), .tlb_entry7(ent[7]),
    .tlb_entry8(ent[8]), .tlb_entry9(ent[9]), .tlb_entry10(ent[10]), .tlb_entry11(ent[11]),
    .tlb_entry12(ent[12]), .tlb_entry13(ent[13]), .tlb_entry14(ent[14]), .tlb_entry15(ent[15])
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic sb_check(input string tag, input logic [79:0] obs);
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL %s scoreboard empty observed=%h", tag, obs);
    end else begin
      chk(tag, obs, exp_q.pop_front());
    end
  endtask

  function automatic logic [3:0] rnext(input logic [3:0] r, input logic [3:0] w);
    return ((r == w) || (r == 4'd0)) ? 4'd15 : r - 4'd1;
  endfunction

  // Drive one op, wait (bounded) for op_done, check latency and the
  // scoreboard entries of that op, then return to IDLE.
  task automatic issue(input logic [1:0] o, input logic [3:0] idx,
                       input logic [31:0] hi, input logic [31:0] l0, input logic [31:0] l1,
                       input int exp_lat, input int tgt, input string tag);
    int lat;
    op_valid = 1'b1; op = o; index = idx;
    entry_hi = hi; entry_lo0 = l0; entry_lo1 = l1;
    tick();
    op_valid = 1'b0;
    lat = 1;
    while (!op_done && lat < 6) begin
      tick();
      lat++;
    end
    chk({tag, "_latency"}, 80'(lat), 80'(exp_lat));
    case (o)
      2'b00: begin
        sb_check({tag, "_rd_hi"},  80'(rd_entry_hi));
        sb_check({tag, "_rd_lo0"}, 80'(rd_entry_lo0));
        sb_check({tag, "_rd_lo1"}, 80'(rd_entry_lo1));
      end
      2'b11: begin
        sb_check({tag, "_probe_index"}, 80'(probe_index));
        sb_check({tag, "_probe_miss"},  80'(probe_miss));
      end
      default: sb_check({tag, "_entry"}, ent[tgt]);
    endcase
    tick();
    chk({tag, "_done_one_cycle"}, 80'(op_done), 80'(0));
  endtask

  initial begin
    bit wr_done;
    // Reset and idle state
    tick();
    tick();
    rst = 1'b0;
    chk("reset_random", 80'(random), 80'(15));
    chk("reset_ready", 80'(op_ready), 80'(1));
    chk("reset_done", 80'(op_done), 80'(0));
    chk("reset_rd", 80'({rd_entry_hi, rd_entry_lo0, rd_entry_lo1}), 80'(0));
    chk("reset_probe", 80'({probe_index, probe_miss}), 80'(0));
    for (int i = 0; i < 16; i++) chk($sformatf("reset_entry%0d", i), ent[i], 80'(0));

    // Free-running Random with Wired = 0
    r_exp = 4'd15;
    for (int k = 0; k < 20; k++) begin
      tick();
      r_exp = rnext(r_exp, 4'd0);
      chk($sformatf("random_free_%0d", k), 80'(random), 80'(r_exp));
      chk("idle_ready", 80'(op_ready), 80'(1));
    end

    // TLBWI index 5
    exp_q.push_back({8'h10, 1'b1, 19'h40001, 24'h2, 1'b1, 1'b1, 24'h1, 1'b1, 1'b1});
    issue(2'b01, 4'd5, 32'h8000_2010, 32'h0000_0047, 32'h0000_0087, 1, 5, "tlbwi5");

    // TLBR index 5
    exp_q.push_back(80'(32'h8000_2010));
    exp_q.push_back(80'(32'h0000_0047));
    exp_q.push_back(80'(32'h0000_0087));
    issue(2'b00, 4'd5, 32'h0, 32'h0, 32'h0, 1, 0, "tlbr5");

    // Probe setup: non-global VPN2 0x40001/ASID 0x10 in 3 and 9, entry 5 moved away
    exp_q.push_back(pack_entry(32'h8000_2010, 32'h46, 32'h86));
    issue(2'b01, 4'd3, 32'h8000_2010, 32'h46, 32'h86, 1, 3, "tlbwi3");
    exp_q.push_back(pack_entry(32'h8000_2010, 32'h46, 32'h86));
    issue(2'b01, 4'd9, 32'h8000_2010, 32'h46, 32'h86, 1, 9, "tlbwi9");
    exp_q.push_back(pack_entry(32'h0000_4011, 32'h0, 32'h0));
    issue(2'b01, 4'd5, 32'h0000_4011, 32'h0, 32'h0, 1, 5, "tlbwi5b");

    exp_q.push_back(80'(3)); exp_q.push_back(80'(0));
    issue(2'b11, 4'd0, 32'h8000_2010, 32'h0, 32'h0, 2, 0, "tlbp_hit3");
    exp_q.push_back(80'(3)); exp_q.push_back(80'(1));
    issue(2'b11, 4'd0, 32'h8000_2011, 32'h0, 32'h0, 2, 0, "tlbp_miss");
    exp_q.push_back(80'(5)); exp_q.push_back(80'(0));
    issue(2'b11, 4'd0, 32'h0000_4011, 32'h0, 32'h0, 2, 0, "tlbp_hit5");

    // Wired = 4, countdown and wrap, TLBWR while Random = 7
    wired = 4'd4;
    wired_we = 1'b1;
    tick();
    wired_we = 1'b0;
    r_exp = 4'd15;
    chk("random_wired_we", 80'(random), 80'(15));
    wr_done = 1'b0;
    for (int k = 0; k < 30; k++) begin
      if (r_exp == 4'd7 && !wr_done) begin
        exp_q.push_back({8'hAB, 1'b0, 19'h7FFFF, 24'h000001, 1'b0, 1'b1,
                         24'hFFFFFF, 1'b0, 1'b1});
        issue(2'b10, 4'd0, 32'hFFFF_E0AB, 32'h3FFF_FFC3, 32'h0000_0042, 1, 7, "tlbwr7");
        r_exp = rnext(rnext(r_exp, 4'd4), 4'd4);
        wr_done = 1'b1;
      end else begin
        tick();
        r_exp = rnext(r_exp, 4'd4);
      end
      chk($sformatf("random_wired_%0d", k), 80'(random), 80'(r_exp));
    end
    chk("tlbwr_entry6_untouched", ent[6], 80'(0));
    chk("tlbwr_entry8_untouched", ent[8], 80'(0));
    chk("tlbwr_entry7_kept", ent[7],
        {8'hAB, 1'b0, 19'h7FFFF, 24'h000001, 1'b0, 1'b1, 24'hFFFFFF, 1'b0, 1'b1});

    // op_valid held high while busy: only the probe executes
    op_valid = 1'b1; op = 2'b11; entry_hi = 32'h8000_2010;
    tick();
    op = 2'b01; index = 4'd0;
    entry_hi = 32'hFFFF_FFFF; entry_lo0 = 32'hFFFF_FFFF; entry_lo1 = 32'hFFFF_FFFF;
    chk("busy_probe_ready", 80'(op_ready), 80'(0));
    chk("busy_probe_done", 80'(op_done), 80'(0));
    tick();
    chk("busy_done_pulse", 80'(op_done), 80'(1));
    chk("busy_probe_index", 80'(probe_index), 80'(3));
    chk("busy_probe_miss", 80'(probe_miss), 80'(0));
    tick();
    op_valid = 1'b0;
    chk("busy_no_extra_done", 80'(op_done), 80'(0));
    chk("busy_entry0_clean", ent[0], 80'(0));
    tick();
    chk("busy_no_late_done", 80'(op_done), 80'(0));
    chk("busy_entry0_still_clean", ent[0], 80'(0));

    // Reset asserted during PROBE
    op_valid = 1'b1; op = 2'b11; entry_hi = 32'h8000_2010;
    tick();
    op_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("rst_probe_done", 80'(op_done), 80'(0));
    chk("rst_probe_ready", 80'(op_ready), 80'(1));
    chk("rst_probe_random", 80'(random), 80'(15));
    for (int i = 0; i < 16; i++) chk($sformatf("rst_probe_entry%0d", i), ent[i], 80'(0));
    tick();
    chk("rst_hold_done", 80'(op_done), 80'(0));
    rst = 1'b0;
    tick();
    chk("rst_after_done", 80'(op_done), 80'(0));
    chk("rst_after_ready", 80'(op_ready), 80'(1));
    chk("sb_drained", 80'(exp_q.size()), 80'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/tlb_table.md
# tlb_table

Storage and maintenance side of the MMU TLB. Holds the 16 × 80-bit entries that feed the combinational `tlb` lookup's `tlb_entry0`..`tlb_entry15` inputs. Executes the CP0 TLB instructions TLBR, TLBWI, TLBWR and TLBP through a small handshake FSM, and maintains the CP0 Random counter.

## Interface
Parameters: none. Entry count (16) and field layout are fixed package constants.

Ports:
- `clk` in 1: clock.
- `rst` in 1: asynchronous, active-high reset.
- `op_valid` in 1: request strobe.
- `op_ready` out 1: request accepted on a cycle where `op_valid & op_ready`.
- `op` in 2: operation code. 00 TLBR, 01 TLBWI, 10 TLBWR, 11 TLBP.
- `index` in 4: CP0 Index[3:0], used by TLBR and TLBWI.
- `wired` in 4: CP0 Wired[3:0].
- `wired_we` in 1: CP0 Wired write this cycle.
- `entry_hi` in 32: VPN2 in [31:13], ASID in [7:0].
- `entry_lo0`, `entry_lo1` in 32 each: PFN in [29:6], D in [2], V in [1], G in [0].
- `op_done` out 1: one-cycle completion pulse.
- `rd_entry_hi`, `rd_entry_lo0`, `rd_entry_lo1` out 32 each: TLBR result. Unused bits are 0. G is replicated into both lo words.
- `probe_index` out 4: TLBP hit index.
- `probe_miss` out 1: TLBP found no match (drives Index.P).
- `random` out 4: CP0 Random.
- `tlb_entry0`..`tlb_entry15` out 80 each: stored entries.

## Operation
- Entry layout: [79:72] ASID, [71] G, [70:52] VPN2, [51:28] PFN1, [27] D1, [26] V1, [25:2] PFN0, [1] D0, [0] V0.
- Written G = `entry_lo0[0] & entry_lo1[0]`. PFN fields take `lo[29:6]`.
- FSM states: IDLE, PROBE, DONE. `op_ready` = (state == IDLE).
- TLBWI: write entry[`index`] at the accept edge, then go to DONE.
- TLBWR: write entry[`random`], using the value present in the accept cycle. Then go to DONE.
- TLBR: register the fields of entry[`index`] into the `rd_*` outputs at the accept edge, then go to DONE.
- TLBP:
  - At the accept edge, register a 16-bit match vector and go to PROBE.
  - Entry i matches when VPN2 == `entry_hi[31:13]` AND (ASID == `entry_hi[7:0]` OR G).
  - PROBE state: the lowest-numbered match is written to `probe_index` and `probe_miss` = 0.
  - No match: `probe_index` is unchanged and `probe_miss` = 1.
  - Then go to DONE.
- DONE: `op_done` = 1 for one cycle, then return to IDLE.
- Random counter:
  - Decrements every cycle.
  - When the current value == `wired` or == 0, the next value is 15.
  - `wired_we` forces the next value to 15 and takes priority over the decrement.
  - TLBWR in the same cycle as `wired_we` uses the pre-update value.
- Requests while not ready are ignored: no state change, no `op_done`.
- Writes never occur during PROBE, so probe results are coherent.

## Timing
- Reset values:
  - All entries 0.
  - `random` = 15.
  - State IDLE, `op_ready` = 1, `op_done` = 0.
  - `rd_*` = 0, `probe_index` = 0, `probe_miss` = 0.
- Latency from accept edge to `op_done` high:
  - TLBWI, TLBWR, TLBR: 1 cycle.
  - TLBP: 2 cycles.
- Written entries appear on the `tlb_entryN` outputs the cycle after the accept edge.
- `rd_*` and `probe_*` are valid when `op_done` rises and hold until the next TLBR or TLBP completes.
- Back-to-back throughput: one op every 2 cycles (3 for TLBP).
- Reset asserted mid-operation: immediate return to IDLE, `op_done` stays 0, entries are cleared.

## Structure
- A shared `mmu_defs` package holds:
  - Entry field bit positions (ASID_HI/LO, G, VPN2_HI/LO, PFN1, D1, V1, PFN0, D0, V0).
  - Op codes TLB_OP_READ/WI/WR/P.
  - `TLB_ENTRIES` = 16 and `RANDOM_RESET` = 15.
- One sub-module, `tlb_random`, holds the Random counter with its Wired and wrap logic.
- Storage, FSM and probe encoder live in `tlb_table`.

## Test plan
- Reset, then observe for 20 cycles with `wired` = 0 → `random` sequence 15,14,…,1,0,15; all `tlb_entryN` = 0; `op_ready` = 1.
- TLBWI:
  - Stimulus: `index` = 5, `entry_hi` = 0x8000_2010, `lo0` = 0x0000_0047, `lo1` = 0x0000_0087.
  - Expected: `tlb_entry5` = {ASID 0x10, G 1, VPN2 0x40001, PFN1 0x2, D1 1, V1 1, PFN0 0x1, D0 1, V0 1}, `op_done` one cycle later.
- TLBR of index 5 → `rd_entry_hi` = 0x8000_2010, `rd_entry_lo0` = 0x47, `rd_entry_lo1` = 0x87.
- TLBP:
  - Setup: VPN2 0x40001 stored in entries 3 and 9 with non-global ASID 0x10.
  - Probe with ASID 0x10 → `probe_index` = 3, `probe_miss` = 0, `op_done` 2 cycles after accept.
  - Probe with ASID 0x11 → `probe_miss` = 1.
- `wired` = 4, `wired_we` pulse → `random` = 15, counts down to 4, then wraps to 15. TLBWR issued while `random` = 7 writes entry 7 only.
- Requests while busy plus reset:
  - `op_valid` held high during PROBE → no extra ops executed.
  - Reset asserted in PROBE → `op_done` never pulses, entries cleared, `random` = 15.
